// File: rtl/rgb_pwm_pkg.sv
// Shared constants, FSM state type and write payload for the RGB PWM generator.
package rgb_pwm_pkg;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned DUTY_W = 8;
    localparam int unsigned CHAN_W = 2;

    // Channel code that addresses every channel at once
    localparam logic [CHAN_W-1:0] CHAN_ALL = 2'd3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    // One configuration write as held between accept and application
    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic [DUTY_W-1:0] duty;
        logic              instant;
    } cfg_t;

    // True when a write addressed to chan affects channel idx
    function automatic logic chan_sel(input logic [CHAN_W-1:0] chan, input int unsigned idx);
        return (chan == CHAN_ALL) || (chan == CHAN_W'(idx));
    endfunction

endpackage

// File: rtl/rgb_pwm_chan.sv
// One PWM channel: target/current duty, one-LSB ramp step, phase compare and output flop.
module rgb_pwm_chan
    import rgb_pwm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] phase_i,
    input  logic              ramp_step_i,
    input  logic              apply_i,
    input  logic [DUTY_W-1:0] wr_duty_i,
    input  logic              wr_instant_i,
    output logic              pwm_o,
    output logic              differ_c
);

    logic [DUTY_W-1:0] cur_q, cur_d;
    logic [DUTY_W-1:0] tgt_q, tgt_d;
    logic              pwm_q;

    // Ramp against the old target first; an applied write then overrides it
    always_comb begin
        cur_d = cur_q;
        tgt_d = tgt_q;
        if (ramp_step_i) begin
            if (cur_q < tgt_q) begin
                cur_d = cur_q + DUTY_W'(1);
            end else if (cur_q > tgt_q) begin
                cur_d = cur_q - DUTY_W'(1);
            end
        end
        if (apply_i) begin
            tgt_d = wr_duty_i;
            if (wr_instant_i) begin
                cur_d = wr_duty_i;
            end
        end
    end

    // Post-update mismatch, registered into busy by the top level
    assign differ_c = (cur_d != tgt_d);

    // Duty registers and registered compare output
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q <= '0;
            tgt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cur_q <= cur_d;
            tgt_q <= tgt_d;
            pwm_q <= (phase_i < cur_q);
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_pwm_gen.sv
// Three-channel RGB PWM generator with shared timebase, write holding FSM and duty ramping.
module rgb_pwm_gen
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE     = 8,
    parameter int unsigned RAMP_PERIODS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHAN_W-1:0] cfg_chan,
    input  logic [DUTY_W-1:0] cfg_duty,
    input  logic              cfg_instant,
    output logic [NUM_CH-1:0] pwm,
    output logic              busy
);

    localparam int unsigned PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned RAMP_W  = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [RAMP_W-1:0]  RAMP_LAST  = RAMP_W'(RAMP_PERIODS - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DUTY_W-1:0]  phase_q, phase_d;
    logic [RAMP_W-1:0]  ramp_q, ramp_d;
    logic               tick_c, period_end_c, ramp_step_c;

    state_e             state_q, state_d;
    cfg_t               hold_q, hold_d;
    cfg_t               cfg_in_c;
    logic               cfg_ready_q, cfg_ready_d;
    logic               accept_c, apply_c;
    logic [NUM_CH-1:0]  apply_ch_c;
    logic [NUM_CH-1:0]  differ_c;
    logic               busy_q;

    assign tick_c       = (presc_q == PRESC_LAST);
    assign period_end_c = tick_c && (phase_q == '1);
    assign ramp_step_c  = period_end_c && (ramp_q == RAMP_LAST);
    assign cfg_in_c     = '{chan: cfg_chan, duty: cfg_duty, instant: cfg_instant};

    // Timebase next state: prescaler, PWM phase and ramp period counter
    always_comb begin
        presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
        phase_d = tick_c ? phase_q + DUTY_W'(1) : phase_q;
        ramp_d  = ramp_q;
        if (period_end_c) begin
            ramp_d = (ramp_q == RAMP_LAST) ? '0 : ramp_q + RAMP_W'(1);
        end
    end

    // Timebase registers
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            phase_q <= '0;
            ramp_q  <= '0;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
            ramp_q  <= ramp_d;
        end
    end

    // Write FSM: capture in IDLE, apply at the next period end seen from PEND
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        apply_c  = 1'b0;
        accept_c = cfg_valid && cfg_ready_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    hold_d  = cfg_in_c;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (period_end_c) begin
                    apply_c = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cfg_ready_d = (state_d == IDLE);
    end

    // FSM state, held write and registered ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    // Route the held write to the addressed channel(s)
    always_comb begin
        apply_ch_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            apply_ch_c[i] = apply_c && chan_sel(hold_q.chan, i);
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_chan
        rgb_pwm_chan u_chan (
            .clk          (clk),
            .rst          (rst),
            .phase_i      (phase_q),
            .ramp_step_i  (ramp_step_c),
            .apply_i      (apply_ch_c[g]),
            .wr_duty_i    (hold_q.duty),
            .wr_instant_i (hold_q.instant),
            .pwm_o        (pwm[g]),
            .differ_c     (differ_c[g])
        );
    end

    // Busy reflects post-update duty state of every channel
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |differ_c;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Directed bench for rgb_pwm_gen with PRESCALE=1, RAMP_PERIODS=1 (one PWM period = 256 clocks).
module tb_rgb_pwm_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_chan;
    logic [7:0] cfg_duty;
    logic       cfg_instant;
    logic [2:0] pwm;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Clocks since reset release; phase seen at a negedge is cyc % 256
    int unsigned cyc = 0;

    int cap_hi [3];
    bit cap_ok [3];

    always #5 clk = ~clk;

    rgb_pwm_gen #(
        .PRESCALE     (1),
        .RAMP_PERIODS (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_chan    (cfg_chan),
        .cfg_duty    (cfg_duty),
        .cfg_instant (cfg_instant),
        .pwm         (pwm),
        .busy        (busy)
    );

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int unsigned target);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cyc == target) return;
        end
        tests_run++;
        tests_failed++;
        $display("FAIL wait_cyc: cycle %0d never reached, now %0d", target, cyc);
    endtask

    // Offer a write from the next negedge until ready; acc = cycle of the handshake
    task automatic do_write(input logic [1:0] chan, input logic [7:0] duty, input logic inst,
                            output int unsigned acc);
        acc = 0;
        @(negedge clk);
        cfg_valid   = 1'b1;
        cfg_chan    = chan;
        cfg_duty    = duty;
        cfg_instant = inst;
        for (int i = 0; i < 1000; i++) begin
            if (cfg_ready === 1'b1) begin
                acc = cyc;
                @(posedge clk);
                @(negedge clk);
                cfg_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        tests_run++;
        tests_failed++;
        $display("FAIL do_write: cfg_ready never rose, cycle %0d", cyc);
    endtask

    // Record one full output period starting at phase 1 (output lags phase by one clock)
    task automatic capture();
        bit seen_low [3];
        bit found;
        found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (cyc % 256 == 1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            tests_run++;
            tests_failed++;
            $display("FAIL capture: period start not found, cycle %0d", cyc);
        end
        for (int c = 0; c < 3; c++) begin
            cap_hi[c]   = 0;
            cap_ok[c]   = 1'b1;
            seen_low[c] = 1'b0;
        end
        for (int j = 0; j < 256; j++) begin
            if (j > 0) @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                if (pwm[c] === 1'b1) begin
                    cap_hi[c]++;
                    if (seen_low[c]) cap_ok[c] = 1'b0;
                end else begin
                    seen_low[c] = 1'b1;
                    if (pwm[c] !== 1'b0) cap_ok[c] = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (pwm !== 3'b000 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: pwm=%b busy=%b ready=%b, expected 000 0 0", i, pwm, busy, cfg_ready);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (cfg_ready !== 1'b1 || pwm !== 3'b000 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: ready=%b pwm=%b busy=%b, expected 1 000 0", cfg_ready, pwm, busy);
        end
    endtask

    task automatic test_instant();
        int unsigned acc;
        int exp_hi [3] = '{64, 0, 0};
        do_reset();
        do_write(2'd0, 8'd64, 1'b1, acc);
        tests_run++;
        if (acc !== 1) begin
            tests_failed++;
            $display("FAIL instant_accept: accepted at cycle %0d, expected 1", acc);
        end
        capture();
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (cap_hi[c] !== exp_hi[c] || !cap_ok[c]) begin
                tests_failed++;
                $display("FAIL instant_ch%0d: high=%0d contiguous=%0d, expected high=%0d contiguous=1",
                         c, cap_hi[c], cap_ok[c], exp_hi[c]);
            end
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL instant_busy: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_ramp();
        int unsigned acc;
        logic exp_busy;
        do_reset();
        do_write(2'd3, 8'd4, 1'b0, acc);
        // Target lands at the first period end; cur then steps 0,1,2,3,4 per period
        for (int k = 0; k < 5; k++) begin
            capture();
            for (int c = 0; c < 3; c++) begin
                tests_run++;
                if (cap_hi[c] !== k || !cap_ok[c]) begin
                    tests_failed++;
                    $display("FAIL ramp_step%0d_ch%0d: high=%0d contiguous=%0d, expected high=%0d contiguous=1",
                             k, c, cap_hi[c], cap_ok[c], k);
                end
            end
            exp_busy = (k < 3);
            tests_run++;
            if (busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL ramp_busy%0d: busy=%b, expected %b", k, busy, exp_busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned acc_a, acc_b;
        int exp_hi [3] = '{0, 32, 16};
        do_reset();
        do_write(2'd1, 8'd32, 1'b1, acc_a);
        tests_run++;
        if (cfg_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_ready_pend: ready=%b, expected 0", cfg_ready);
        end
        do_write(2'd2, 8'd16, 1'b1, acc_b);
        tests_run++;
        if (acc_b !== 256) begin
            tests_failed++;
            $display("FAIL b2b_second_accept: accepted at cycle %0d, expected 256", acc_b);
        end
        capture();
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (cap_hi[c] !== exp_hi[c] || !cap_ok[c]) begin
                tests_failed++;
                $display("FAIL b2b_ch%0d: high=%0d contiguous=%0d, expected high=%0d contiguous=1",
                         c, cap_hi[c], cap_ok[c], exp_hi[c]);
            end
        end
    endtask

    task automatic test_coincident();
        int unsigned acc;
        do_reset();
        wait_cyc(254);
        do_write(2'd0, 8'd100, 1'b1, acc);
        tests_run++;
        if (acc !== 255) begin
            tests_failed++;
            $display("FAIL coinc_accept: accepted at cycle %0d, expected 255", acc);
        end
        tests_run++;
        if (cfg_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL coinc_ready: ready=%b, expected 0", cfg_ready);
        end
        capture();
        tests_run++;
        if (cap_hi[0] !== 0 || !cap_ok[0]) begin
            tests_failed++;
            $display("FAIL coinc_deferred: high=%0d contiguous=%0d, expected high=0", cap_hi[0], cap_ok[0]);
        end
        capture();
        tests_run++;
        if (cap_hi[0] !== 100 || !cap_ok[0]) begin
            tests_failed++;
            $display("FAIL coinc_applied: high=%0d contiguous=%0d, expected high=100 contiguous=1",
                     cap_hi[0], cap_ok[0]);
        end
    endtask

    task automatic test_extremes();
        int unsigned acc;
        do_reset();
        do_write(2'd3, 8'd255, 1'b1, acc);
        capture();
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (cap_hi[c] !== 255 || !cap_ok[c]) begin
                tests_failed++;
                $display("FAIL duty255_ch%0d: high=%0d contiguous=%0d, expected high=255 contiguous=1",
                         c, cap_hi[c], cap_ok[c]);
            end
        end
        do_write(2'd3, 8'd0, 1'b1, acc);
        capture();
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (cap_hi[c] !== 0 || !cap_ok[c]) begin
                tests_failed++;
                $display("FAIL duty0_ch%0d: high=%0d, expected 0", c, cap_hi[c]);
            end
        end
    endtask

    task automatic test_reset_mid_ramp();
        int unsigned acc;
        do_reset();
        do_write(2'd3, 8'd200, 1'b0, acc);
        // cur is 2 during cycles 768..1023, so output is high at 769
        wait_cyc(769);
        tests_run++;
        if (pwm !== 3'b111 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midramp_pre: pwm=%b busy=%b, expected 111 1", pwm, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (pwm !== 3'b000 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midramp_rst: pwm=%b busy=%b ready=%b, expected 000 0 0", pwm, busy, cfg_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        capture();
        tests_run++;
        if (cap_hi[0] !== 0 || cap_hi[1] !== 0 || cap_hi[2] !== 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midramp_after: high=%0d/%0d/%0d busy=%b, expected 0/0/0 0",
                     cap_hi[0], cap_hi[1], cap_hi[2], busy);
        end
    endtask

    initial begin
        rst         = 1'b1;
        cfg_valid   = 1'b0;
        cfg_chan    = 2'd0;
        cfg_duty    = 8'd0;
        cfg_instant = 1'b0;
        test_reset();
        test_instant();
        test_ramp();
        test_back_to_back();
        test_coincident();
        test_extremes();
        test_reset_mid_ramp();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
